// File: rtl/pkt_gen_esw.sv
// pkt_gen_esw: configurable pktin frame generator (metadata, Ethernet header, payload, gap)
module pkt_gen_esw #(
    parameter int unsigned NUM_W     = 16,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned GAP_W     = 8,
    parameter logic [15:0] ETHERTYPE = 16'h0800
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_W-1:0]   cfg_pkt_num,
    input  logic [LEN_W-1:0]   cfg_len_beats,
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic [3:0]         cfg_last_inv,
    input  logic [5:0]         cfg_inport,
    input  logic [7:0]         cfg_smid,
    input  logic [47:0]        cfg_dmac,
    input  logic [47:0]        cfg_smac,
    input  logic               cfg_pat,
    input  logic               pktin_alf,
    output logic [133:0]       pktin_data,
    output logic               pktin_data_wr,
    output logic               pktin_valid,
    output logic               pktin_valid_wr,
    output logic               busy,
    output logic               done,
    output logic [31:0]        sent_cnt
);

    localparam int unsigned BEAT_W = 134;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned LB_W   = LEN_W + 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_META0 = 3'd2,
        S_META1 = 3'd3,
        S_DATA  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t           state;

    // Run configuration captured at start
    logic [NUM_W-1:0] r_pkt_num;
    logic [LEN_W-1:0] r_len;
    logic [GAP_W-1:0] r_gap;
    logic [3:0]       r_last_inv;
    logic [5:0]       r_inport;
    logic [7:0]       r_smid;
    logic [47:0]      r_dmac;
    logic [47:0]      r_smac;
    logic             r_pat;

    logic [LEN_W-1:0] beat_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [NUM_W-1:0] seq;
    logic             stop_pend;

    logic [LEN_W-1:0]  len_clamp_c;
    logic [LB_W-1:0]   frame_bytes_c;
    logic [11:0]       byte_len_c;
    logic [BEAT_W-1:0] meta0_c;
    logic [BEAT_W-1:0] meta1_c;
    logic [LEN_W-1:0]  nidx_c;
    logic              last_c;
    logic [DATA_W-1:0] pat_c;
    logic [DATA_W-1:0] payload_c;
    logic [BEAT_W-1:0] data_c;
    logic              frame_last_c;
    logic              end_c;
    logic              launch_c;
    logic              in_frame_c;

    // Beat contents and control decisions derived from the current state
    always_comb begin
        len_clamp_c   = (cfg_len_beats < LEN_W'(2)) ? LEN_W'(2) : cfg_len_beats;
        frame_bytes_c = {r_len, 4'b0000} - LB_W'(r_last_inv);
        byte_len_c    = 12'(frame_bytes_c);
        meta0_c       = {2'b01, 4'b0000, 2'b00, r_inport, 12'h000, byte_len_c,
                         r_smid, 8'h01, 80'h0};
        meta1_c       = {2'b11, 4'b0000, 128'h0};

        nidx_c        = (state == S_META1) ? '0 : beat_idx + LEN_W'(1);
        last_c        = (nidx_c == r_len - LEN_W'(1));
        pat_c         = r_pat ? {16{8'(nidx_c)}} : '0;

        if (nidx_c == '0) begin
            payload_c = {r_dmac, r_smac, ETHERTYPE, 16'h4500};
        end else if (nidx_c == LEN_W'(1)) begin
            payload_c = {32'(seq), pat_c[95:0]};
        end else begin
            payload_c = pat_c;
        end
        data_c        = {(last_c ? 2'b10 : 2'b11), (last_c ? r_last_inv : 4'b0000), payload_c};

        frame_last_c  = (state == S_DATA) && (beat_idx == r_len - LEN_W'(1));
        in_frame_c    = (state == S_META0) || (state == S_META1) || (state == S_DATA);
        end_c         = stop || stop_pend || ((r_pkt_num != '0) && (seq == r_pkt_num));
        launch_c      = (state == S_WAIT)
                     || (frame_last_c && (r_gap == '0))
                     || ((state == S_GAP) && !stop && (gap_cnt == '0));
    end

    // Frame sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            r_pkt_num      <= '0;
            r_len          <= LEN_W'(2);
            r_gap          <= '0;
            r_last_inv     <= '0;
            r_inport       <= '0;
            r_smid         <= '0;
            r_dmac         <= '0;
            r_smac         <= '0;
            r_pat          <= 1'b0;
            beat_idx       <= '0;
            gap_cnt        <= '0;
            seq            <= '0;
            stop_pend      <= 1'b0;
            pktin_data     <= '0;
            pktin_data_wr  <= 1'b0;
            pktin_valid    <= 1'b0;
            pktin_valid_wr <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sent_cnt       <= '0;
        end else begin
            pktin_data_wr  <= 1'b0;
            pktin_valid    <= 1'b0;
            pktin_valid_wr <= 1'b0;
            done           <= 1'b0;

            if (stop && in_frame_c) begin
                stop_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        r_pkt_num  <= cfg_pkt_num;
                        r_len      <= len_clamp_c;
                        r_gap      <= cfg_gap;
                        r_last_inv <= cfg_last_inv;
                        r_inport   <= cfg_inport;
                        r_smid     <= cfg_smid;
                        r_dmac     <= cfg_dmac;
                        r_smac     <= cfg_smac;
                        r_pat      <= cfg_pat;
                        seq        <= '0;
                        stop_pend  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_WAIT;
                    end
                end
                S_META0: begin
                    pktin_data    <= meta1_c;
                    pktin_data_wr <= 1'b1;
                    state         <= S_META1;
                end
                S_META1: begin
                    pktin_data    <= data_c;
                    pktin_data_wr <= 1'b1;
                    beat_idx      <= nidx_c;
                    state         <= S_DATA;
                end
                S_DATA: begin
                    if (!frame_last_c) begin
                        pktin_data    <= data_c;
                        pktin_data_wr <= 1'b1;
                        beat_idx      <= nidx_c;
                        if (last_c) begin
                            pktin_valid    <= 1'b1;
                            pktin_valid_wr <= 1'b1;
                            seq            <= seq + NUM_W'(1);
                            sent_cnt       <= sent_cnt + 32'd1;
                        end
                    end else if (r_gap != '0) begin
                        gap_cnt <= r_gap - GAP_W'(1);
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: ;
            endcase

            // Frame-start decision: end the run, issue META0, or hold for alf
            if (launch_c) begin
                if (end_c) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end else if (!pktin_alf) begin
                    pktin_data    <= meta0_c;
                    pktin_data_wr <= 1'b1;
                    state         <= S_META0;
                end else begin
                    state <= S_WAIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_gen_esw.sv
// Directed testbench for pkt_gen_esw
module tb_pkt_gen_esw;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [15:0]  cfg_pkt_num = '0;
    logic [7:0]   cfg_len_beats = '0;
    logic [7:0]   cfg_gap = '0;
    logic [3:0]   cfg_last_inv = '0;
    logic [5:0]   cfg_inport = '0;
    logic [7:0]   cfg_smid = '0;
    logic [47:0]  cfg_dmac = 48'h0011_2233_4455;
    logic [47:0]  cfg_smac = 48'h6677_8899_AABB;
    logic         cfg_pat = 1'b0;
    logic         pktin_alf = 1'b0;
    logic [133:0] pktin_data;
    logic         pktin_data_wr;
    logic         pktin_valid;
    logic         pktin_valid_wr;
    logic         busy;
    logic         done;
    logic [31:0]  sent_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Captured write beats with the cycle they appeared in
    logic [133:0] q_data[$];
    int           q_cyc[$];
    int           cyc = 0;
    int           n_vwr = 0;
    bit           done_seen = 1'b0;
    int           done_cyc = 0;
    int           s_cyc;
    int           a_cyc;

    pkt_gen_esw dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .cfg_pkt_num    (cfg_pkt_num),
        .cfg_len_beats  (cfg_len_beats),
        .cfg_gap        (cfg_gap),
        .cfg_last_inv   (cfg_last_inv),
        .cfg_inport     (cfg_inport),
        .cfg_smid       (cfg_smid),
        .cfg_dmac       (cfg_dmac),
        .cfg_smac       (cfg_smac),
        .cfg_pat        (cfg_pat),
        .pktin_alf      (pktin_alf),
        .pktin_data     (pktin_data),
        .pktin_data_wr  (pktin_data_wr),
        .pktin_valid    (pktin_valid),
        .pktin_valid_wr (pktin_valid_wr),
        .busy           (busy),
        .done           (done),
        .sent_cnt       (sent_cnt)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pktin_data_wr) begin
            q_data.push_back(pktin_data);
            q_cyc.push_back(cyc);
        end
        if (pktin_valid_wr && pktin_valid) n_vwr = n_vwr + 1;
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_cyc.delete();
        n_vwr     = 0;
        done_seen = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
    endtask

    task automatic set_cfg(input int num, input int len, input int gap, input int inv,
                           input int inport, input int smid, input bit pat);
        cfg_pkt_num   = 16'(num);
        cfg_len_beats = 8'(len);
        cfg_gap       = 8'(gap);
        cfg_last_inv  = 4'(inv);
        cfg_inport    = 6'(inport);
        cfg_smid      = 8'(smid);
        cfg_pat       = pat;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); s_cyc = cyc;
        #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!done_seen && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_done_seen"}, 134'(done_seen), 134'(1));
    endtask

    task automatic wait_beats(input string tag, input int cnt, input int max);
        int n = 0;
        while (q_data.size() < cnt && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_beats_seen"}, 134'(q_data.size() >= cnt), 134'(1));
    endtask

    function automatic logic [1:0] flag_of(input int i);
        logic [133:0] b;
        b = q_data[i];
        return b[133:132];
    endfunction

    function automatic logic [31:0] seq_of(input int i);
        logic [133:0] b;
        b = q_data[i];
        return b[127:96];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [133:0] b;
        int tails;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_data", pktin_data, '0);
        chk("rst_ctl", 134'({pktin_data_wr, pktin_valid, pktin_valid_wr, busy, done}), '0);
        chk("rst_sent", 134'(sent_cnt), '0);

        // 1. Single frame
        do_reset();
        set_cfg(1, 7, 5, 14, 0, 8'h80, 1'b0);
        pulse_start();
        wait_done("t1", 200);
        chk("t1_nbeats", 134'(q_data.size()), 134'(9));
        chk("t1_first_lat", 134'(q_cyc[0]), 134'(s_cyc + 2));
        chk("t1_meta0", q_data[0], {2'b01, 4'h0, 2'b00, 6'd0, 12'h000, 12'h062, 8'h80, 8'h01, 80'h0});
        chk("t1_meta1", q_data[1], {2'b11, 132'h0});
        chk("t1_hdr", q_data[2], {2'b11, 4'h0, 48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h0800, 16'h4500});
        chk("t1_seq", q_data[3], {2'b11, 4'h0, 128'h0});
        chk("t1_tail", q_data[8], {2'b10, 4'hE, 128'h0});
        chk("t1_contig", 134'(q_cyc[8] - q_cyc[0]), 134'(8));
        chk("t1_vwr", 134'(n_vwr), 134'(1));
        chk("t1_gap_done", 134'(done_cyc - q_cyc[8]), 134'(6));
        chk("t1_sent", 134'(sent_cnt), 134'(1));
        chk("t1_busy", 134'(busy), 134'(0));

        // 2. Ten frames, gap 5
        do_reset();
        set_cfg(10, 7, 5, 0, 3, 8'h11, 1'b0);
        pulse_start();
        wait_done("t2", 1000);
        chk("t2_nbeats", 134'(q_data.size()), 134'(90));
        for (int f = 0; f < 10; f++) begin
            chk("t2_seq", 134'(seq_of(f * 9 + 3)), 134'(f));
            chk("t2_head", 134'(flag_of(f * 9)), 134'(2'b01));
            if (f > 0) chk("t2_gap", 134'(q_cyc[f * 9] - q_cyc[f * 9 - 1]), 134'(6));
        end
        chk("t2_vwr", 134'(n_vwr), 134'(10));
        chk("t2_sent", 134'(sent_cnt), 134'(10));

        // 3. Backpressure
        do_reset();
        pktin_alf = 1'b1;
        set_cfg(1, 7, 2, 0, 0, 0, 1'b0);
        pulse_start();
        repeat (20) @(negedge clk);
        #1;
        chk("t3_no_wr", 134'(q_data.size()), 134'(0));
        chk("t3_busy", 134'(busy), 134'(1));
        @(posedge clk); #1 pktin_alf = 1'b0;
        @(posedge clk); a_cyc = cyc;
        repeat (3) @(posedge clk);
        #1 pktin_alf = 1'b1;
        wait_done("t3", 100);
        pktin_alf = 1'b0;
        chk("t3_nbeats", 134'(q_data.size()), 134'(9));
        chk("t3_meta0_edge", 134'(q_cyc[0]), 134'(a_cyc + 1));
        chk("t3_contig", 134'(q_cyc[8] - q_cyc[0]), 134'(8));

        // 4. Back-to-back frames
        do_reset();
        set_cfg(3, 7, 0, 0, 0, 0, 1'b0);
        pulse_start();
        wait_done("t4", 200);
        chk("t4_nbeats", 134'(q_data.size()), 134'(27));
        chk("t4_contig", 134'(q_cyc[26] - q_cyc[0]), 134'(26));
        chk("t4_tail1", 134'({flag_of(8), flag_of(9)}), 134'(4'b1001));
        chk("t4_tail2", 134'({flag_of(17), flag_of(18)}), 134'(4'b1001));
        chk("t4_done", 134'(done_cyc - q_cyc[26]), 134'(1));

        // 5a. Continuous run, stop during frame 2, start while busy ignored
        do_reset();
        set_cfg(0, 4, 3, 0, 0, 0, 1'b0);
        pulse_start();
        wait_beats("t5", 2, 50);
        cfg_len_beats = 8'd9;
        pulse_start();
        wait_beats("t5", 8, 50);
        pulse_stop();
        wait_done("t5", 200);
        chk("t5_nbeats", 134'(q_data.size()), 134'(12));
        chk("t5_f1_tail", 134'(flag_of(5)), 134'(2'b10));
        chk("t5_f2_head", 134'(flag_of(6)), 134'(2'b01));
        chk("t5_f2_seq", 134'(seq_of(9)), 134'(1));
        chk("t5_f2_tail", 134'(flag_of(11)), 134'(2'b10));
        chk("t5_gap_done", 134'(done_cyc - q_cyc[11]), 134'(4));
        chk("t5_sent", 134'(sent_cnt), 134'(2));

        // 5b. Stop during the gap ends the run at once
        do_reset();
        set_cfg(0, 4, 10, 0, 0, 0, 1'b0);
        pulse_start();
        wait_beats("t5b", 6, 50);
        pulse_stop();
        wait_done("t5b", 50);
        chk("t5b_done", 134'(done_cyc - q_cyc[5]), 134'(2));
        repeat (15) @(negedge clk);
        #1;
        chk("t5b_nbeats", 134'(q_data.size()), 134'(6));
        chk("t5b_sent", 134'(sent_cnt), 134'(1));

        // 6a. Reset mid-frame
        do_reset();
        set_cfg(2, 7, 0, 0, 0, 0, 1'b1);
        pulse_start();
        wait_beats("t6", 12, 50);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("t6_wr", 134'(pktin_data_wr), 134'(0));
        chk("t6_data", pktin_data, '0);
        chk("t6_sent", 134'(sent_cnt), 134'(0));
        chk("t6_busy", 134'(busy), 134'(0));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        tails = 0;
        for (int i = 0; i < q_data.size(); i++) if (flag_of(i) == 2'b10) tails++;
        chk("t6_tails", 134'(tails), 134'(1));

        // 6b. len=1 clamps to 2 data beats
        do_reset();
        set_cfg(1, 1, 0, 0, 0, 0, 1'b1);
        pulse_start();
        wait_done("t6b", 50);
        chk("t6b_nbeats", 134'(q_data.size()), 134'(4));
        b = q_data[0];
        chk("t6b_len", 134'(b[107:96]), 134'(12'h020));
        chk("t6b_last", q_data[3], {2'b10, 4'h0, 32'h0, {12{8'h01}}});

        // 6c. Beat-index payload pattern
        do_reset();
        set_cfg(1, 6, 0, 3, 0, 0, 1'b1);
        pulse_start();
        wait_done("t6c", 50);
        chk("t6c_idx3", q_data[5], {2'b11, 4'h0, {16{8'h03}}});
        chk("t6c_idx5", q_data[7], {2'b10, 4'h3, {16{8'h05}}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_gen_esw.md
Name: pkt_gen_esw

Overview:
Synthesizable, run-time configurable generator of the 134-bit pktin frame format (2-bit head/body/tail flag, 4-bit invalid-byte count, 128-bit data). Emits N frames, or runs continuously until stopped. Each frame is two metadata beats, an Ethernet header beat and payload beats, followed by a programmable inter-frame gap. Frame starts are gated by downstream almost-full. Sits in front of the ESW ingress (pktin_*) as a built-in traffic source for bring-up and loopback tests.

Parameters:
NUM_W, 16, width of cfg_pkt_num and of the sequence counter
LEN_W, 8, width of cfg_len_beats (data beats per frame, excluding the 2 metadata beats)
GAP_W, 8, width of cfg_gap (idle cycles between frames)
ETHERTYPE, 16'h0800, ethertype placed in the header beat

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; latches all cfg_* and starts a run; ignored while busy
stop  in  1  pulse; finish the current frame and its gap, then go idle
cfg_pkt_num  in  NUM_W  frames per run; 0 = continuous
cfg_len_beats  in  LEN_W  data beats per frame; values below 2 are clamped to 2
cfg_gap  in  GAP_W  idle cycles after each frame
cfg_last_inv  in  4  invalid-byte count for the last beat
cfg_inport  in  6  metadata inport field
cfg_smid  in  8  metadata smid field
cfg_dmac  in  48  destination MAC
cfg_smac  in  48  source MAC
cfg_pat  in  1  payload pattern: 0 = zeros, 1 = beat index
pktin_alf  in  1  downstream almost full
pktin_data  out  134  frame beat
pktin_data_wr  out  1  beat strobe
pktin_valid  out  1  frame-valid flag, driven only with pktin_valid_wr
pktin_valid_wr  out  1  frame-valid strobe, asserted on the last beat
busy  out  1  a run is in progress
done  out  1  one-cycle pulse at the end of a run
sent_cnt  out  32  frames emitted since reset; wraps

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- States:
  - IDLE: waits for start.
  - META0, META1, DATA: the beat states of a frame.
  - GAP: counts the inter-frame gap.
  - WAIT: a frame start is pending but blocked by pktin_alf.
- Frame-start rule: META0 is registered at edge E only if pktin_alf==0 at E. Otherwise the block holds in WAIT with pktin_data_wr=0.
  - With alf low, the first beat appears one cycle after start is sampled.
  - alf is ignored once META0 has been issued; the frame always completes.
- META0 beat fields, bits 133..0:
  - [133:132] = 01, [131:128] = 0, [127:126] = 00
  - [125:120] = inport, [119:108] = 0
  - [107:96] = frame byte length = len*16 - last_inv, truncated to 12 bits
  - [95:88] = smid, [87:80] = 8'h01, [79:0] = 0
- META1 beat: {11, 0000, 128'h0}.
- DATA beat index 0: {11, 0000, dmac, smac, ETHERTYPE, 16'h4500}.
- DATA beat index 1: top 32 data bits = zero-extended seq; remaining bits follow the pattern.
- DATA beats index 2 and above: pattern only.
  - Pattern 0: all zeros.
  - Pattern 1: the 8-bit beat index replicated across all 16 bytes of the beat.
- Last DATA beat (index len-1):
  - flag 10, [131:128] = last_inv.
  - pktin_valid=1 and pktin_valid_wr=1 on this beat only.
  - sent_cnt increments on this beat.
- Frame length: exactly len+2 consecutive wr cycles.
- Gap: exactly cfg_gap cycles with wr=0 follow each frame before the next META0 is eligible. With cfg_gap=0, frames run back to back (tail beat immediately followed by head beat).
- seq: cleared at start; increments per frame; wraps modulo 2^NUM_W.
- Run end:
  - Finite run: ends after the gap of frame cfg_pkt_num.
  - Continuous run: ends after the gap of the frame in progress when stop arrives. A stop arriving in GAP or WAIT ends the run immediately, with no new frame.
  - At run end: busy drops, and done pulses in the same cycle the block returns to IDLE.
- busy: rises the cycle after start is accepted.
- start while busy: ignored; cfg is not re-latched.
- stop outside a run: ignored.
- start and stop in the same cycle while IDLE: start wins; stop is ignored.
- Reset mid-frame: the next cycle has all outputs 0 and no tail beat is emitted; seq, sent_cnt and the state machine clear.

Test Plan:
1. Single frame: start with pkt_num=1, len=7, gap=5, inport=0, smid=0x80, last_inv=14, alf=0.
   - 9 wr beats; META0 length field = 12'h062, [95:80] = 16'h8001.
   - Beat 8 is {10, 1110, ...} with valid=valid_wr=1.
   - 5 idle cycles, then done; sent_cnt=1.
2. Ten frames with gap=5: 90 wr beats; exactly 5 idle cycles between tails and heads; seq in DATA beat 1 counts 0..9; sent_cnt=10.
3. Backpressure: alf high at start for 20 cycles gives no wr. Then alf low gives META0 on the same edge. alf raised mid-frame does not interrupt the frame.
4. gap=0, pkt_num=3: 27 contiguous wr cycles; each flag-10 beat is immediately followed by a flag-01 beat.
5. Continuous run:
   - stop during frame 2 → frame 2 completes, gap elapses, IDLE, done.
   - start pulses while busy are ignored.
   - separately, stop during GAP → IDLE with no further META0.
6. Boundaries:
   - rst mid-frame → wr=0, data=0, sent_cnt=0 next cycle.
   - len=1 → clamped to 4 beats total.
   - cfg_pat=1 → beat index 3 data = 128'h0303…03.
